// File: rtl/m_conv_stream.sv
// rtl/m_conv_stream.sv - streaming KxK fixed-point convolution with line buffer and 3-stage MAC pipeline
module m_conv_stream #(
  parameter int DW    = 16,
  parameter int FRAC  = 12,
  parameter int K     = 3,
  parameter int IMG_W = 96,
  parameter int IMG_H = 96
) (
  input  logic                         clk_in,
  input  logic                         rst_n,
  input  logic                         frame_start,
  input  logic                         in_valid,
  input  logic [DW-1:0]                in_data,
  input  logic                         w_we,
  input  logic [$clog2(K*K+1)-1:0]     w_addr,
  input  logic [DW-1:0]                w_data,
  input  logic                         relu_en,
  output logic                         out_valid,
  output logic [DW-1:0]                out_data,
  output logic                         busy,
  output logic                         done
);

  localparam int NW     = K * K;
  localparam int AW     = $clog2(NW + 1);
  localparam int ACC    = 2 * DW + $clog2(NW) + 1;
  localparam int CW     = $clog2(IMG_W + 1);
  localparam int RW     = $clog2(IMG_H + 1);
  localparam int TOTAL  = (IMG_W - K + 1) * (IMG_H - K + 1);
  localparam int OW     = $clog2(TOTAL + 1);
  localparam int SR_RAW = (K - 1) * IMG_W + K - 1;
  localparam int SR_LEN = (SR_RAW > 0) ? SR_RAW : 1;

  localparam logic [AW-1:0] BIAS_ADDR = AW'(NW);
  localparam logic signed [ACC-1:0] SAT_MAX = {{(ACC-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC-1:0] SAT_MIN = {{(ACC-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [DW-1:0]    wgt  [NW];
  logic signed [DW-1:0]    bias;
  logic signed [DW-1:0]    sr   [SR_LEN];
  logic signed [DW-1:0]    win  [NW];
  logic signed [2*DW-1:0]  prod [NW];
  logic signed [ACC-1:0]   row_acc [K];
  logic signed [ACC-1:0]   rsum    [K];
  logic signed [ACC-1:0]   total;
  logic signed [ACC-1:0]   shifted;
  logic signed [DW-1:0]    result;

  logic [RW-1:0] row, cur_r;
  logic [CW-1:0] col, cur_c;
  logic [OW-1:0] out_cnt;
  logic          v1, v2;
  logic          all_in, accept, last_col, complete, last_out;

  // frame_start rewinds the position so a coincident pixel lands at (0,0)
  always_comb begin
    all_in   = (row == RW'(IMG_H));
    accept   = in_valid && (frame_start || (busy && !all_in));
    cur_r    = frame_start ? '0 : row;
    cur_c    = frame_start ? '0 : col;
    last_col = (cur_c == CW'(IMG_W - 1));
    complete = accept && (cur_r >= RW'(K - 1)) && (cur_c >= CW'(K - 1));
    last_out = out_valid && (out_cnt == OW'(TOTAL)) && busy && !frame_start;
  end

  // Window tap (i,j) is the pixel a rows and b columns behind the newest one
  for (genvar gi = 0; gi < K; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_col
      localparam int IDX = (K - 1 - gi) * IMG_W + (K - 1 - gj);
      if (IDX == 0) begin : g_new
        assign win[gi*K+gj] = in_data;
      end else begin : g_old
        assign win[gi*K+gj] = sr[IDX-1];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < K; i++) begin
      row_acc[i] = '0;
      for (int j = 0; j < K; j++) begin
        row_acc[i] = row_acc[i] + ACC'(prod[i*K+j]);
      end
    end
  end

  always_comb begin
    total = '0;
    for (int i = 0; i < K; i++) begin
      total = total + rsum[i];
    end
    total   = total + (ACC'(bias) <<< FRAC) + (ACC'(1) <<< (FRAC - 1));
    shifted = total >>> FRAC;
    if (shifted > SAT_MAX) begin
      result = SAT_MAX[DW-1:0];
    end else if (shifted < SAT_MIN) begin
      result = SAT_MIN[DW-1:0];
    end else begin
      result = shifted[DW-1:0];
    end
    if (relu_en && result[DW-1]) begin
      result = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      row       <= '0;
      col       <= '0;
      out_cnt   <= '0;
      bias      <= '0;
      for (int i = 0; i < NW; i++) begin
        wgt[i] <= '0;
      end
    end else begin
      done <= last_out;
      if (frame_start) begin
        busy <= 1'b1;
      end else if (last_out) begin
        busy <= 1'b0;
      end
      if (accept) begin
        col <= last_col ? '0 : cur_c + 1'b1;
        row <= last_col ? cur_r + 1'b1 : cur_r;
      end else if (frame_start) begin
        row <= '0;
        col <= '0;
      end
      v1        <= complete;
      v2        <= v1 && !frame_start;
      out_valid <= v2 && !frame_start;
      if (frame_start) begin
        out_cnt <= '0;
      end else if (v2) begin
        out_cnt <= out_cnt + 1'b1;
      end
      if (v2 && !frame_start) begin
        out_data <= result;
      end
      if (w_we && !busy) begin
        if (w_addr == BIAS_ADDR) begin
          bias <= w_data;
        end else if (w_addr < BIAS_ADDR) begin
          wgt[w_addr] <= w_data;
        end
      end
    end
  end

  // Datapath registers carry no reset; their valid bits gate everything downstream
  always_ff @(posedge clk_in) begin
    if (accept) begin
      sr[0] <= in_data;
      for (int i = 1; i < SR_LEN; i++) begin
        sr[i] <= sr[i-1];
      end
    end
    if (complete) begin
      for (int i = 0; i < NW; i++) begin
        prod[i] <= (2*DW)'(win[i]) * (2*DW)'(wgt[i]);
      end
    end
    if (v1) begin
      for (int i = 0; i < K; i++) begin
        rsum[i] <= row_acc[i];
      end
    end
  end

endmodule

// File: tb/tb_m_conv_stream.sv
// tb/tb_m_conv_stream.sv - randomized self-checking bench for m_conv_stream on a 5x5 frame
module tb_m_conv_stream;
  localparam int DW = 16, FRAC = 12, K = 3, W = 5, H = 5, NPIX = 25, AW = 4;

  logic clk_in = 1'b0, rst_n = 1'b0, frame_start = 1'b0, in_valid = 1'b0;
  logic w_we = 1'b0, relu_en = 1'b0;
  logic [DW-1:0] in_data = '0, w_data = '0;
  logic [AW-1:0] w_addr = '0;
  logic out_valid, busy, done;
  logic [DW-1:0] out_data;

  int checks = 0, failures = 0, cyc = 0;
  int pix [NPIX];
  int wt  [9];
  int bias = 0;
  int out_q[$], ocyc_q[$], obusy_q[$], done_q[$], dbusy_q[$], acc_q[$];

  m_conv_stream #(.DW(DW), .FRAC(FRAC), .K(K), .IMG_W(W), .IMG_H(H)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .frame_start(frame_start), .in_valid(in_valid),
    .in_data(in_data), .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .relu_en(relu_en),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (out_valid) begin
      out_q.push_back(int'($signed(out_data)));
      ocyc_q.push_back(cyc);
      obusy_q.push_back(int'(busy));
    end
    if (done) begin
      done_q.push_back(cyc);
      dbusy_q.push_back(int'(busy));
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Plain valid-convolution reference with round half-up, saturation and ReLU
  function automatic int model(input int r, input int c);
    longint s = 0;
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        s += longint'(pix[(r - K + 1 + i) * W + (c - K + 1 + j)]) * longint'(wt[i * K + j]);
    s += longint'(bias) * (longint'(1) << FRAC);
    s += longint'(1) << (FRAC - 1);
    s = s >>> FRAC;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (relu_en && s < 0) s = 0;
    return int'(s);
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_q();
    out_q.delete(); ocyc_q.delete(); obusy_q.delete();
    done_q.delete(); dbusy_q.delete(); acc_q.delete();
  endtask

  task automatic load_weights();
    for (int a = 0; a < 10; a++) begin
      w_we   = 1'b1;
      w_addr = AW'(a);
      w_data = (a < 9) ? DW'(wt[a]) : DW'(bias);
      tick();
    end
    w_we = 1'b0;
  endtask

  task automatic set_w(input int v, input int center_only);
    for (int i = 0; i < 9; i++) wt[i] = (center_only != 0 && i != 4) ? 0 : v;
  endtask

  task automatic set_pix(input int v);
    for (int i = 0; i < NPIX; i++) pix[i] = v;
  endtask

  task automatic send(input int idx);
    in_valid = 1'b1;
    in_data  = DW'(pix[idx]);
    if (idx / W >= K - 1 && idx % W >= K - 1) acc_q.push_back(cyc);
  endtask

  task automatic start_partial(input int n);
    clear_q();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(pix[i]);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    int n;
    n = out_q.size();
    check({tag, "_n_out"}, n, 9);
    check({tag, "_n_done"}, done_q.size(), 1);
    for (int k = 0; k < 9; k++) begin
      if (k < n) begin
        check($sformatf("%s_val%0d", tag, k), out_q[k], model(K - 1 + k / 3, K - 1 + k % 3));
        check($sformatf("%s_lat%0d", tag, k), ocyc_q[k], acc_q[k] + 3);
      end
    end
    if (n > 0 && done_q.size() > 0) begin
      check({tag, "_done_cyc"}, done_q[0], ocyc_q[n-1] + 1);
      check({tag, "_busy_at_done"}, dbusy_q[0], 0);
      check({tag, "_busy_at_last"}, obusy_q[n-1], 1);
    end
  endtask

  task automatic run_frame(input string tag, input int gap_pct, input bit noise, input bit coincide);
    int idx;
    clear_q();
    idx = 0;
    frame_start = 1'b1;
    if (coincide) begin
      send(0);
      idx = 1;
    end
    tick();
    frame_start = 1'b0;
    in_valid    = 1'b0;
    while (idx < NPIX) begin
      w_we = 1'b0;
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        in_valid = 1'b0;
        if (noise) begin
          w_we   = 1'b1;
          w_addr = AW'($urandom_range(0, 9));
          w_data = DW'($urandom);
        end
      end else begin
        send(idx);
        idx++;
      end
      tick();
      in_valid = 1'b0;
    end
    w_we = 1'b0;
    // Surplus pixels past the frame end must be ignored
    repeat (2) begin
      in_valid = 1'b1;
      in_data  = DW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    for (int t = 0; t < 40 && done_q.size() == 0; t++) tick();
    repeat (4) tick();
    check_frame(tag);
  endtask

  initial begin
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    set_w(4096, 0); bias = 0; set_pix(2048); load_weights();
    run_frame("all_ones", 0, 1'b0, 1'b0);

    set_w(4096, 1); load_weights();
    for (int i = 0; i < NPIX; i++) pix[i] = i * 1024;
    run_frame("center", 0, 1'b0, 1'b0);

    set_w(1, 1); load_weights(); set_pix(2048);
    run_frame("round_pos", 0, 1'b0, 1'b0);
    set_pix(-2048);
    run_frame("round_neg", 0, 1'b0, 1'b0);

    set_w(-4096, 0); load_weights(); set_pix(4096);
    run_frame("sat_neg", 0, 1'b0, 1'b0);
    relu_en = 1'b1;
    run_frame("relu", 0, 1'b0, 1'b0);
    set_w(4096, 0); load_weights();
    run_frame("sat_pos", 0, 1'b0, 1'b0);
    relu_en = 1'b0;

    set_pix(2048);
    run_frame("gaps_noise", 40, 1'b1, 1'b0);
    run_frame("after_noise", 20, 1'b0, 1'b1);

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 9; i++) wt[i] = int'($urandom_range(0, 8192)) - 4096;
      bias = int'($urandom_range(0, 8192)) - 4096;
      for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(0, 65535)) - 32768;
      relu_en = 1'($urandom_range(0, 1));
      load_weights();
      run_frame($sformatf("rand%0d", f), int'($urandom_range(0, 50)), 1'b1, 1'($urandom_range(0, 1)));
    end
    relu_en = 1'b0;

    set_w(4096, 0); bias = 0; set_pix(2048); load_weights();
    start_partial(13);
    run_frame("abort", 0, 1'b0, 1'b1);

    start_partial(14);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    clear_q();
    repeat (8) tick();
    check("rst_mid_n_out", out_q.size(), 0);
    check("rst_mid_n_done", done_q.size(), 0);
    check("rst_mid_busy", busy, 0);
    set_w(0, 0); bias = 0;
    for (int i = 0; i < NPIX; i++) pix[i] = int'($urandom_range(0, 65535)) - 32768;
    run_frame("cleared_w", 10, 1'b0, 1'b0);
    set_w(4096, 0); set_pix(2048); load_weights();
    run_frame("restart", 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
